sram_arb2_cm0: RTL

Two-requester arbiter in front of the 128-bit AHB-lite SRAM wrapper. Port 0 serves the CM0 bus bridge and port 1 serves the polynomial engine. It grants one transfer per cycle, round-robin. It drives the wrapper's single AHB-lite slave port with a registered address phase and a registered data phase, and it returns read data and completion strobes to the owning requester.

---
 rtl/sram_arb2_cm0_if.sv | 45 ++++
 rtl/sram_arb2_cm0.sv | 112 +++++++++++
 2 files changed

// File: rtl/sram_arb2_cm0_if.sv
// Bus bundle between the two requesters, the arbiter and the AHB-lite SRAM wrapper.
// master = the arbiter (drives the wrapper and answers requesters); slave = everything around it.
interface sram_arb2_cm0_if #(
  parameter int DWIDTH = 128,
  parameter int AWIDTH = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [AWIDTH-1:0] addr0;
  logic [AWIDTH-1:0] addr1;
  logic [3:0]        size0;
  logic [3:0]        size1;
  logic [DWIDTH-1:0] wdata0;
  logic [DWIDTH-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DWIDTH-1:0] rdata;
  logic              hsel;
  logic [AWIDTH-1:0] haddr;
  logic [3:0]        hsize;
  logic              hwrite;
  logic [DWIDTH-1:0] hwdata;
  logic [DWIDTH-1:0] hrdata;
  logic              hready;
  logic              hresp;
  logic              err;

  modport master (
    input  req0, req1, we0, we1, addr0, addr1, size0, size1, wdata0, wdata1,
    input  hrdata, hready, hresp,
    output gnt0, gnt1, done0, done1, rdata,
    output hsel, haddr, hsize, hwrite, hwdata, err
  );

  modport slave (
    output req0, req1, we0, we1, addr0, addr1, size0, size1, wdata0, wdata1,
    output hrdata, hready, hresp,
    input  gnt0, gnt1, done0, done1, rdata,
    input  hsel, haddr, hsize, hwrite, hwdata, err
  );
endinterface

// File: rtl/sram_arb2_cm0.sv
// Round-robin 2:1 arbiter onto the AHB-lite SRAM wrapper: gnt same cycle, done 2 cycles later; hready=0 freezes all state.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins a tie).
module sram_arb2_cm0 #(
  parameter int DWIDTH = 128,
  parameter int AWIDTH = 32
) (
  input logic         hclk,
  input logic         hreset,
  sram_arb2_cm0_if.master bus
);

  typedef struct packed {
    logic              write;
    logic [3:0]        size;
    logic [AWIDTH-1:0] addr;
  } cmd_t;

  logic              ap_vld;
  logic              ap_owner;
  cmd_t              ap_cmd;
  logic [DWIDTH-1:0] ap_wdat;
  logic              dp_vld;
  logic              dp_owner;
  logic              dp_write;
  logic [DWIDTH-1:0] dp_wdat;
  logic              err_q;

  logic              win0;
  logic              win1;
  cmd_t              win_cmd;
  logic [DWIDTH-1:0] win_wdat;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign win0 = bus.req0;
  assign win1 = bus.req1 & ~bus.req0;
`else
  // last_gnt names the port granted most recently; the other port wins a tie.
  logic last_gnt;

  assign win0 = bus.req0 & (~bus.req1 | last_gnt);
  assign win1 = bus.req1 & (~bus.req0 | ~last_gnt);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      last_gnt <= 1'b1;
    end else if (bus.gnt0) begin
      last_gnt <= 1'b0;
    end else if (bus.gnt1) begin
      last_gnt <= 1'b1;
    end
  end
`endif

  assign bus.gnt0 = win0 & bus.hready;
  assign bus.gnt1 = win1 & bus.hready;

  always_comb begin
    win_cmd  = '0;
    win_wdat = '0;
    if (win0) begin
      win_cmd  = '{write: bus.we0, size: bus.size0, addr: bus.addr0};
      win_wdat = bus.wdata0;
    end else if (win1) begin
      win_cmd  = '{write: bus.we1, size: bus.size1, addr: bus.addr1};
      win_wdat = bus.wdata1;
    end
  end

  // An empty address slot is cleared so the wrapper never sees stale address/control.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      ap_vld   <= 1'b0;
      ap_owner <= 1'b0;
      ap_cmd   <= '0;
      ap_wdat  <= '0;
      dp_vld   <= 1'b0;
      dp_owner <= 1'b0;
      dp_write <= 1'b0;
      dp_wdat  <= '0;
    end else if (bus.hready) begin
      dp_vld   <= ap_vld;
      dp_owner <= ap_owner;
      dp_write <= ap_vld & ap_cmd.write;
      dp_wdat  <= ap_wdat;
      ap_vld   <= win0 | win1;
      ap_owner <= win1;
      ap_cmd   <= win_cmd;
      ap_wdat  <= win_wdat;
    end
  end

  // Error is latched on the completing (hready=1) cycle of the two-cycle error response.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      err_q <= 1'b0;
    end else if (bus.hready & dp_vld & bus.hresp) begin
      err_q <= 1'b1;
    end
  end

  assign bus.hsel   = ap_vld;
  assign bus.haddr  = ap_cmd.addr;
  assign bus.hsize  = ap_cmd.size;
  assign bus.hwrite = ap_cmd.write;
  assign bus.hwdata = dp_write ? dp_wdat : '0;
  assign bus.err    = err_q;

  assign bus.done0 = bus.hready & dp_vld & ~dp_owner;
  assign bus.done1 = bus.hready & dp_vld &  dp_owner;
  assign bus.rdata = bus.hrdata;

endmodule
